id_regfile_ctrl: RTL and testbench
==================================

Name: id_regfile_ctrl

Overview:
- Combined instruction-decode core for the 5-stage MIPS-style pipeline.
- Contains a 32x32 general-purpose register file: two combinational read ports, one synchronous write port, one debug read port for the board display.
- Contains a combinational main control decoder that maps the 6-bit opcode to datapath control signals.
- Sits inside the ID stage, which registers its outputs into the ID/EX latch.

Parameters:
- None. Widths are fixed: 32 registers, 32-bit data, 5-bit addresses, 6-bit opcode.

Ports:
- clk  input  1  register-file write clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- opcode  input  6  instruction bits [31:26].
- ra1  input  5  read address A (instr [25:21], rs).
- ra2  input  5  read address B (instr [20:16], rt).
- wa  input  5  write address (instr [15:11]).
- wdata  input  32  write data from writeback.
- we  input  1  write enable from writeback.
- s  input  5  debug read select (board switches).
- rdata1  output  32  register[ra1].
- rdata2  output  32  register[ra2].
- showdat  output  32  register[s].
- RegDst  output  1  control output.
- Jump  output  1  control output.
- ALUsrc  output  1  control output.
- MemtoReg  output  1  control output.
- MemRead  output  1  control output.
- MemWrite  output  1  control output.
- Branch  output  1  control output.
- RegWrite  output  1  control output.
- ALUop  output  2  control output.

Behaviour:
- One clock (clk). Reset is asynchronous and active-high (rst).
- Reset: while rst=1, all 32 registers clear to 0 immediately, with no clock edge needed. Read outputs therefore show 0. Control outputs are purely combinational and are unaffected by reset.
- Register 0 is hardwired to 0. Writes to address 0 are ignored, and reads of address 0 always return 0.
- Write: on rising clk with rst=0, we=1 and wa!=0, register[wa] <= wdata. With we=0 there is no change.
- Reads: rdata1, rdata2 and showdat are combinational from the current register contents, with zero-cycle latency.
- Same-cycle write and read of the same address: no bypass. The read returns the old value until the clock edge, then the new value.
- Reset asserted in the same cycle as a write: reset wins, and the register stays 0.
- Control decode is combinational from opcode. Every output not listed for an opcode is 0.
  - R-type 000000: RegDst=1, RegWrite=1, ALUop=10.
  - lw 100011: ALUsrc=1, MemtoReg=1, MemRead=1, RegWrite=1, ALUop=00.
  - sw 101011: ALUsrc=1, MemWrite=1, ALUop=00.
  - beq 000100: Branch=1, ALUop=01.
  - j 000010: Jump=1, ALUop=00.
  - addi 001000: ALUsrc=1, RegWrite=1, ALUop=00.
  - Any other opcode: all outputs 0, ALUop=00. This is a NOP, with no register or memory write.
- Outputs must never carry X for a defined opcode. There is no latch inference: decode uses a default assignment.

Test Plan:
- Reset: pulse rst=1 with no clk edge, then set ra1=5, ra2=31, s=7 -> rdata1=rdata2=showdat=0 immediately.
- Write/read:
  - we=1, wa=5, wdata=32'hDEADBEEF, one rising edge -> rdata1(ra1=5)=32'hDEADBEEF and showdat(s=5)=32'hDEADBEEF.
  - Then we=0, wdata=32'h1234, one edge -> register 5 unchanged.
- R0: we=1, wa=0, wdata=32'hFFFFFFFF, one edge -> rdata1(ra1=0)=0.
- No bypass: before the edge, ra2=9 with wa=9, we=1, wdata=32'h55 -> rdata2 shows the old value (0). After the edge -> 32'h55.
- Decode sweep:
  - 000000 -> RegDst=1, RegWrite=1, ALUop=10, rest 0.
  - 100011 -> ALUsrc=1, MemtoReg=1, MemRead=1, RegWrite=1.
  - 101011 -> ALUsrc=1, MemWrite=1.
  - 000100 -> Branch=1, ALUop=01.
  - 000010 -> Jump=1.
  - 001000 -> ALUsrc=1, RegWrite=1.
  - 111111 -> all 0.
- Reset mid-use: load registers 1..31 with their index values, assert rst asynchronously between edges -> all reads return 0 at once. After release, the next write to reg 3 of 32'hA -> reg 3 = 32'hA, and the others remain 0.

Source files
------------

// File: rtl/id_regfile_ctrl.sv
// Purpose: ID-stage core. It holds the 32x32 register file (r0 hardwired to 0) and the main opcode decoder.
// Latency: all reads and decode are combinational (0 cycles), and writes land on the rising clk edge.
// Backpressure: none. A write is accepted on every cycle, and there is no read-during-write bypass.
module id_regfile_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  opcode,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic [4:0]  wa,
  input  logic [31:0] wdata,
  input  logic        we,
  input  logic [4:0]  s,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2,
  output logic [31:0] showdat,
  output logic        RegDst,
  output logic        Jump,
  output logic        ALUsrc,
  output logic        MemtoReg,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        Branch,
  output logic        RegWrite,
  output logic [1:0]  ALUop
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  // Entry 0 is never written. It only gets cleared on reset, so it reads as 0 anyway.
  logic [31:0] regs [0:31];

  // Register storage: an async clear takes priority over any same-cycle write, and writes to r0 are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= 32'd0;
      end
    end else if (we && (wa != 5'd0)) begin
      regs[wa] <= wdata;
    end
  end

  // Read ports see the current contents only. A value being written appears after the edge.
  assign rdata1  = (ra1 == 5'd0) ? 32'd0 : regs[ra1];
  assign rdata2  = (ra2 == 5'd0) ? 32'd0 : regs[ra2];
  assign showdat = (s   == 5'd0) ? 32'd0 : regs[s];

  // Main control decode: every output defaults to 0, so an unknown opcode becomes a NOP.
  always_comb begin
    RegDst   = 1'b0;
    Jump     = 1'b0;
    ALUsrc   = 1'b0;
    MemtoReg = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    Branch   = 1'b0;
    RegWrite = 1'b0;
    ALUop    = 2'b00;
    case (opcode)
      OP_RTYPE: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
        ALUop    = 2'b10;
      end
      OP_LW: begin
        ALUsrc   = 1'b1;
        MemtoReg = 1'b1;
        MemRead  = 1'b1;
        RegWrite = 1'b1;
      end
      OP_SW: begin
        ALUsrc   = 1'b1;
        MemWrite = 1'b1;
      end
      OP_BEQ: begin
        Branch   = 1'b1;
        ALUop    = 2'b01;
      end
      OP_J: begin
        Jump     = 1'b1;
      end
      OP_ADDI: begin
        ALUsrc   = 1'b1;
        RegWrite = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_id_regfile_ctrl.sv
// Purpose: a scoreboard bench for id_regfile_ctrl, covering reset, write/read, r0, the no-bypass case and decode.
// Latency: each expected value is queued when its stimulus is driven and popped once the outputs have settled.
// Backpressure: not applicable. The clock is stepped explicitly so that resets can land between edges.
module tb_id_regfile_ctrl;

  logic        clk;
  logic        rst;
  logic [5:0]  opcode;
  logic [4:0]  ra1;
  logic [4:0]  ra2;
  logic [4:0]  wa;
  logic [31:0] wdata;
  logic        we;
  logic [4:0]  s;
  logic [31:0] rdata1;
  logic [31:0] rdata2;
  logic [31:0] showdat;
  logic        RegDst;
  logic        Jump;
  logic        ALUsrc;
  logic        MemtoReg;
  logic        MemRead;
  logic        MemWrite;
  logic        Branch;
  logic        RegWrite;
  logic [1:0]  ALUop;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] exp_q [$];
  string       tag_q [$];

  id_regfile_ctrl dut (
    .clk(clk), .rst(rst), .opcode(opcode), .ra1(ra1), .ra2(ra2), .wa(wa),
    .wdata(wdata), .we(we), .s(s), .rdata1(rdata1), .rdata2(rdata2),
    .showdat(showdat), .RegDst(RegDst), .Jump(Jump), .ALUsrc(ALUsrc),
    .MemtoReg(MemtoReg), .MemRead(MemRead), .MemWrite(MemWrite),
    .Branch(Branch), .RegWrite(RegWrite), .ALUop(ALUop)
  );

  // Control outputs packed as {RegDst,Jump,ALUsrc,MemtoReg,MemRead,MemWrite,Branch,RegWrite,ALUop[1:0]}
  function automatic logic [9:0] ctrl_model(input logic [5:0] op);
    case (op)
      6'b000000: return 10'b1000000110;
      6'b100011: return 10'b0011100100;
      6'b101011: return 10'b0010010000;
      6'b000100: return 10'b0000001001;
      6'b000010: return 10'b0100000000;
      6'b001000: return 10'b0010000100;
      default:   return 10'b0000000000;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input string tag, input logic [31:0] v);
    exp_q.push_back(v);
    tag_q.push_back(tag);
  endtask

  task automatic pop_cmp(input logic [31:0] obs);
    logic [31:0] e;
    string       t;
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", obs, 32'hxxxx_xxxx);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      chk(t, obs, e);
    end
  endtask

  task automatic tick();
    #5 clk = 1'b1;
    #5 clk = 1'b0;
    #1;
  endtask

  initial begin
    clk = 1'b0; rst = 1'b0; opcode = 6'd0; ra1 = 5'd0; ra2 = 5'd0;
    wa = 5'd0; wdata = 32'd0; we = 1'b0; s = 5'd0;

    // Async reset with no clock edge.
    #1 rst = 1'b1;
    #1 ra1 = 5'd5; ra2 = 5'd31; s = 5'd7;
    push_exp("rst_rdata1", 32'd0); push_exp("rst_rdata2", 32'd0); push_exp("rst_showdat", 32'd0);
    #1 pop_cmp(rdata1); pop_cmp(rdata2); pop_cmp(showdat);
    rst = 1'b0;
    #1;

    // Write then read.
    we = 1'b1; wa = 5'd5; wdata = 32'hDEADBEEF; ra1 = 5'd5; s = 5'd5;
    push_exp("wr_rdata1", 32'hDEADBEEF); push_exp("wr_showdat", 32'hDEADBEEF);
    tick();
    pop_cmp(rdata1); pop_cmp(showdat);

    we = 1'b0; wdata = 32'h1234;
    push_exp("we0_hold", 32'hDEADBEEF);
    tick();
    pop_cmp(rdata1);

    // Writes to r0 are dropped.
    we = 1'b1; wa = 5'd0; wdata = 32'hFFFFFFFF; ra1 = 5'd0; s = 5'd0;
    push_exp("r0_rdata1", 32'd0); push_exp("r0_showdat", 32'd0);
    tick();
    pop_cmp(rdata1); pop_cmp(showdat);

    // No bypass: the old value shows until the edge.
    we = 1'b1; wa = 5'd9; wdata = 32'h55; ra2 = 5'd9;
    push_exp("nobyp_before", 32'd0);
    #1 pop_cmp(rdata2);
    push_exp("nobyp_after", 32'h55);
    tick();
    pop_cmp(rdata2);
    we = 1'b0;

    // Decode sweep across all 64 opcodes.
    for (int op = 0; op < 64; op++) begin
      opcode = op[5:0];
      push_exp($sformatf("decode_%02h", op), {22'd0, ctrl_model(op[5:0])});
      #1 pop_cmp({22'd0, RegDst, Jump, ALUsrc, MemtoReg, MemRead, MemWrite, Branch, RegWrite, ALUop});
    end

    // Load registers 1..31 with their index values.
    we = 1'b1;
    for (int i = 1; i < 32; i++) begin
      wa = i[4:0]; wdata = i;
      tick();
    end
    we = 1'b0;
    for (int i = 0; i < 32; i++) begin
      ra1 = i[4:0];
      push_exp($sformatf("load_r%0d", i), i);
      #1 pop_cmp(rdata1);
    end

    // Reset between edges clears everything at once.
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < 32; i++) begin
      ra1 = i[4:0];
      push_exp($sformatf("midrst_r%0d", i), 32'd0);
      #1 pop_cmp(rdata1);
    end

    // A write during reset loses.
    we = 1'b1; wa = 5'd12; wdata = 32'hCAFE; ra2 = 5'd12;
    push_exp("rst_wins", 32'd0);
    tick();
    pop_cmp(rdata2);
    rst = 1'b0;
    #1;

    // After release, only reg 3 takes the new write.
    we = 1'b1; wa = 5'd3; wdata = 32'hA;
    tick();
    we = 1'b0;
    for (int i = 0; i < 32; i++) begin
      s = i[4:0];
      push_exp($sformatf("post_r%0d", i), (i == 3) ? 32'hA : 32'd0);
      #1 pop_cmp(showdat);
    end

    if (exp_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL scoreboard_leftover: got %0d entries expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
